// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: FSM states, command encodings
// and frame-geometry helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int cnt_width(input int addr_w, input int data_w);
    return $clog2(frame_len(addr_w, data_w) + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, followed by a registered
// copy of the synchronised level used to detect rising and falling edges.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
    end
  end

  assign level = sync[1];
  assign rise  = sync[1] & ~prev;
  assign fall  = ~sync[1] & prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral holding NUM_REGS x DATA_W configuration registers.
// Register readback over cipo is compiled in when SPI_READBACK_EN is defined.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       cs,
  input  logic                       copi,
  output logic                       cipo,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int               FRAME_LEN   = frame_len(ADDR_W, DATA_W);
  localparam int               CNT_W       = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]  NUM_REGS_C  = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, copi_lvl;

  spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .din(sclk), .level(), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge u_cs   (.clk(clk), .rst_n(rst_n), .din(cs),   .level(), .rise(cs_rise),   .fall(cs_fall));
  spi_sync_edge u_copi (.clk(clk), .rst_n(rst_n), .din(copi), .level(copi_lvl), .rise(), .fall());

  spi_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] shreg_nxt;
  logic                 overrun;
  logic                 commit_pend;
  logic [DATA_W-1:0]    regs [NUM_REGS];

  logic                 frame_cmd;
  logic [ADDR_W-1:0]    frame_addr;
  logic [DATA_W-1:0]    frame_data;
  logic                 frame_ok;

  assign shreg_nxt  = {shreg[FRAME_LEN-2:0], copi_lvl};
  assign frame_cmd  = shreg[FRAME_LEN-1];
  assign frame_addr = shreg[DATA_W +: ADDR_W];
  assign frame_data = shreg[DATA_W-1:0];
  assign frame_ok   = (frame_cmd == CMD_WRITE) && !overrun && ({1'b0, frame_addr} < NUM_REGS_C);

  // cs rise is checked before sclk rise so a coincident sclk edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      overrun     <= 1'b0;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= SHIFT;
            cnt     <= '0;
            shreg   <= '0;
            overrun <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            shreg <= shreg_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) state <= DONE;
          end
        end
        DONE: begin
          if (cs_rise) begin
            state       <= IDLE;
            commit_pend <= frame_ok;
          end else if (sclk_rise) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Commit one cycle after the FSM accepts the frame; the shift register is
  // still intact because the next cs fall cannot arrive that soon.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this bank is a set of control flops, not a RAM, so every entry is
      // reset; downstream logic must see known values straight out of reset.
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      wr_addr  <= '0;
      wr_valid <= 1'b0;
    end else begin
      wr_valid <= commit_pend;
      if (commit_pend) begin
        wr_addr <= frame_addr;
        for (int k = 0; k < NUM_REGS; k++) begin
          if (frame_addr == ADDR_W'(k)) regs[k] <= frame_data;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_q
    assign regs_q[k*DATA_W +: DATA_W] = regs[k];
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] rd_word;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_load;

  assign rd_addr = shreg_nxt[ADDR_W-1:0];
  assign rd_load = (state == SHIFT) && sclk_rise && !cs_rise &&
                   (cnt == CNT_W'(ADDR_W)) && (shreg_nxt[ADDR_W] == CMD_READ);

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // an unmatched address would hold its old value and infer a latch.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_word = regs[k];
    end
  end

  // The fall right after the load is skipped so the MSB is still on cipo at
  // the first data-phase rise; later falls advance one bit each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (state == IDLE || cs_rise) begin
      shadow <= '0;
    end else if (rd_load) begin
      shadow <= rd_word;
    end else if (sclk_fall && cnt > CNT_W'(ADDR_W + 1)) begin
      shadow <= shadow << 1;
    end
  end

  assign cipo = shadow[DATA_W-1];
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI (mode 0) peripheral that terminates the controller's serial link and holds a bank of NUM_REGS configuration registers of DATA_W bits each, driving them in parallel to downstream logic (output-enable, PWM-enable, duty-cycle and similar control). It generalises the fixed five-register, 8-bit, write-only peripheral. It adds:

- parametrised register count, data width and address width;
- out-of-range and malformed-frame rejection;
- a per-write commit strobe;
- optional register readback over CIPO.

All SPI pins are asynchronous to clk and are synchronised internally.

## Interface
Parameters:
- NUM_REGS, 5, number of registers (1..2^ADDR_W)
- DATA_W, 8, register width in bits (≥1)
- ADDR_W, 7, address field width in bits (≥1)

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- sclk  input  1  SPI clock from controller, idle low
- cs  input  1  SPI chip select, active low
- copi  input  1  controller-out serial data
- cipo  output  1  peripheral-out serial data (readback)
- regs_q  output  NUM_REGS*DATA_W  register bank, register k at bits [k*DATA_W +: DATA_W]
- wr_valid  output  1  one-cycle pulse when a write commits
- wr_addr  output  ADDR_W  address of the last committed write

## Operation
- Frame layout (MSB first): 1 command bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. FRAME_LEN = 1 + ADDR_W + DATA_W.
- copi is sampled on sclk rising edges.
- A frame is delimited by cs falling, then cs rising.
- FSM states:
  - IDLE → SHIFT on synchronised cs fall: clears bit counter and shift register.
  - SHIFT: each sclk rise shifts one bit and increments the counter.
  - SHIFT → DONE when the counter reaches FRAME_LEN.
  - SHIFT or DONE → IDLE on cs rise.
  - An sclk rise in DONE sets an overrun flag.
- Commit happens on the cs rise from DONE, with the command bit = 1, no overrun and address < NUM_REGS. On commit:
  - the addressed register ← data field;
  - wr_addr ← address;
  - wr_valid pulses for one cycle.
- Frames are discarded silently (no register change, no wr_valid) when any of these hold:
  - cs rises in SHIFT (short frame);
  - the frame overran;
  - address ≥ NUM_REGS;
  - the command bit = 0.
- Simultaneous synchronised sclk rise and cs rise in the same cycle: cs rise wins, and the sclk edge is ignored.
- Reset (any time, including mid-frame):
  - regs_q = 0, wr_valid = 0, wr_addr = 0, cipo = 0;
  - FSM to IDLE, counter, shift register and overrun flag cleared.
- cs low at reset release does not start a frame. A cs fall must be observed first.

## Timing
- Each of sclk, cs and copi passes through a 2-flop synchroniser. Edge detection compares the second stage with a registered copy.
- copi is taken from the second stage, aligned with the detected sclk edge.
- Commit latency: regs_q and wr_addr update, and wr_valid rises, at the 3rd rising clk edge after the rising clk edge that first samples cs high.
- wr_valid is high for exactly one clk cycle.
- Constraints on the controller:
  - sclk high and low phases each ≥ 4 clk periods;
  - cs setup before the first sclk rise ≥ 4 clk periods;
  - cs hold after the last sclk fall ≥ 4 clk periods;
  - cs high between frames ≥ 4 clk periods.
- Back-to-back frames meeting these constraints are all processed. No frame is lost.

## Configuration
- SPI_READBACK_EN defined (readback compiled in):
  - In a read frame, the addressed register (0 if address ≥ NUM_REGS) is loaded into a DATA_W shadow register on the sclk rise that completes the address field.
  - The shadow register's MSB drives cipo immediately.
  - Each subsequent synchronised sclk fall shifts the next bit out, so the controller samples DATA_W bits on the following rises.
  - cipo = 0 outside read frames and after cs rise.
  - Write frames are unaffected.
- SPI_READBACK_EN undefined: cipo tied to 0, no shadow register, and read frames are discarded as above.

## Structure
- Shared package spi_pkg holds:
  - the FSM state enum (IDLE, SHIFT, DONE);
  - the command encodings CMD_WRITE = 1'b1 and CMD_READ = 1'b0;
  - a function computing FRAME_LEN and the counter width ($clog2(FRAME_LEN+1)).
- Sub-module spi_sync_edge: 2-flop synchroniser plus registered edge detector with outputs level, rise and fall. It is instantiated for sclk, cs and copi (edges unused for copi).

## Test plan
- Reset, then write frame cmd=1, addr=2, data=0xA5 at sclk = clk/10 → regs_q[23:16] = 0xA5, all others 0; one wr_valid pulse with wr_addr = 2, appearing 3 clk edges after cs high is sampled.
- Write addr=4 data=0xFF, then a frame with cs raised after 10 bits → reg 4 = 0xFF; the short frame changes nothing and gives no wr_valid.
- Write addr=5 (≥ NUM_REGS), data=0x33 → no register change, no wr_valid. Then a 17-sclk overrun frame to addr=0 → reg 0 unchanged.
- With SPI_READBACK_EN, write addr=1 data=0x3C, then read addr=1 → cipo bits sampled on the 8 data-phase sclk rises = 0x3C. A read of addr=6 returns 0x00.
- Assert rst_n low after 9 bits of a write to addr=0 data=0x81, release, then raise cs → no commit, regs_q = 0, cipo = 0.
- Two back-to-back writes, addr=0 data=0x11 then addr=3 data=0x22, with the minimum 4-clk cs-high gap → both commit, with two distinct wr_valid pulses in order.
